// File: rtl/mem_stage_if.sv
// Bus bundle between the execute/controller side and the memory stage.
// The memory stage connects through the slave modport.
interface mem_stage_if #(
   parameter int EX_TO_MEM_WD = 142,
   parameter int MEM_TO_WB_WD = 136,
   parameter int STALL_BUS    = 6
);
   logic [STALL_BUS-1:0]    stall;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [31:0]             data_sram_rdata;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [MEM_TO_WB_WD-1:0] mem_to_id_forwarding;
   logic                    mem_is_load;

   modport master (
      output stall, ex_to_mem_bus, data_sram_rdata,
      input  mem_to_wb_bus, mem_to_id_forwarding, mem_is_load
   );

   modport slave (
      input  stall, ex_to_mem_bus, data_sram_rdata,
      output mem_to_wb_bus, mem_to_id_forwarding, mem_is_load
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: registers the EX->MEM bus, completes loads from the
// synchronous data SRAM and holds the read data stable across stalls.
module mem_stage (
   input logic         clk,
   input logic         rst,
   mem_stage_if.slave  bus
);
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef struct packed {
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi_result;
      logic [31:0] lo_result;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;

   typedef struct packed {
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi_result;
      logic [31:0] lo_result;
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_to_wb_t;

   ex_to_mem_t bus_r;
   logic [31:0] rdata_h;
   logic        first_r;
   logic        advance;
   logic        bubble;
   logic        held;
   logic [31:0] ld_data;
   mem_to_wb_t  wb;

   assign advance = (bus.stall[3] == NO_STOP);
   assign bubble  = (bus.stall[3] == STOP) && (bus.stall[4] == NO_STOP);
   assign held    = (bus.stall[3] == STOP) && (bus.stall[4] == STOP);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_r   <= '0;
         rdata_h <= '0;
         first_r <= 1'b0;
      end else begin
         if (bubble) begin
            bus_r <= '0;
         end else if (advance) begin
            bus_r <= bus.ex_to_mem_bus;
         end
         first_r <= advance;
         // SRAM data is only valid in the load's first cycle; freeze it for the stall.
         if (first_r && held) begin
            rdata_h <= bus.data_sram_rdata;
         end
      end
   end

   assign ld_data = first_r ? bus.data_sram_rdata : rdata_h;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wb           = '0;
      wb.hi_we     = bus_r.hi_we;
      wb.lo_we     = bus_r.lo_we;
      wb.hi_result = bus_r.hi_result;
      wb.lo_result = bus_r.lo_result;
      wb.pc        = bus_r.pc;
      wb.rf_we     = bus_r.rf_we;
      wb.rf_waddr  = bus_r.rf_waddr;
      wb.rf_wdata  = bus_r.sel_rf_res ? ld_data : bus_r.ex_result;
   end

   assign bus.mem_to_wb_bus        = wb;
   assign bus.mem_to_id_forwarding = wb;
   assign bus.mem_is_load          = bus_r.data_ram_en && (bus_r.data_ram_wen == 4'b0000);
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations,
// then randomized traffic against a behavioural stage model.
module tb_mem_stage;
   logic clk = 1'b0;
   logic rst;

   mem_stage_if bus_if ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: which instruction occupies the stage, how many cycles it
   // has been there, and the SRAM word it saw on arrival.
   logic [141:0] m_instr = '0;
   int           m_age   = 1;
   logic [31:0]  m_ld    = '0;
   bit           m_valid = 1'b0;

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [141:0] mk_bus(
      input logic hi_we, input logic lo_we, input logic [31:0] hi_res, input logic [31:0] lo_res,
      input logic [31:0] pc, input logic en, input logic [3:0] wen, input logic sel,
      input logic rf_we, input logic [4:0] waddr, input logic [31:0] ex_res);
      return {hi_we, lo_we, hi_res, lo_res, pc, en, wen, sel, rf_we, waddr, ex_res};
   endfunction

   // Output an instruction must produce, given the load word it observed.
   function automatic logic [135:0] expect_wb(input logic [141:0] ins, input logic [31:0] ld);
      logic [31:0] wdata;
      wdata = ins[38] ? ld : ins[31:0];
      return {ins[141:44], ins[37], ins[36:32], wdata};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_instr = '0;
         m_age   = 1;
         m_ld    = '0;
         m_valid = 1'b1;
      end else if (bus_if.stall[3] && !bus_if.stall[4]) begin
         m_instr = '0;
         m_age   = 1;
      end else if (!bus_if.stall[3]) begin
         m_instr = bus_if.ex_to_mem_bus;
         m_age   = 0;
      end else begin
         m_age++;
      end
   end

   always @(negedge clk) begin
      logic [31:0]  ld;
      logic [135:0] exp_wb;
      if (m_valid) begin
         if (m_age == 0) m_ld = bus_if.data_sram_rdata;
         ld     = m_ld;
         exp_wb = expect_wb(m_instr, ld);
         check("model_wb", bus_if.mem_to_wb_bus, exp_wb);
         check("model_fwd", bus_if.mem_to_id_forwarding, exp_wb);
         check("model_is_load", {135'd0, bus_if.mem_is_load},
               {135'd0, m_instr[43] && (m_instr[42:39] == 4'b0000)});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [141:0] ld_bus;
      logic [141:0] r_bus;
      logic [3:0]   wen;

      // Reset with nonzero inputs
      rst                    = 1'b1;
      bus_if.stall           = 6'b0;
      bus_if.ex_to_mem_bus   = {142{1'b1}};
      bus_if.data_sram_rdata = 32'hFFFF_FFFF;
      cyc(); cyc();
      at_neg();
      check("reset_wb", bus_if.mem_to_wb_bus, 136'd0);
      check("reset_fwd", bus_if.mem_to_id_forwarding, 136'd0);
      check("reset_is_load", {135'd0, bus_if.mem_is_load}, 136'd0);

      // ALU pass-through
      rst                  = 1'b0;
      bus_if.ex_to_mem_bus = mk_bus(0, 0, 0, 0, 32'hBFC0_0000, 0, 4'h0, 0, 1, 5'd5, 32'h1234_5678);
      cyc();
      at_neg();
      check("alu_wb", bus_if.mem_to_wb_bus,
            {1'b0, 1'b0, 32'h0, 32'h0, 32'hBFC0_0000, 1'b1, 5'd5, 32'h1234_5678});

      // Load, no stall
      ld_bus                 = mk_bus(0, 0, 0, 0, 32'hBFC0_0004, 1, 4'h0, 1, 1, 5'd8, 32'h0000_1000);
      bus_if.ex_to_mem_bus   = ld_bus;
      bus_if.data_sram_rdata = 32'hDEAD_BEEF;
      cyc();
      at_neg();
      check("load_wdata", {104'd0, bus_if.mem_to_wb_bus[31:0]}, {104'd0, 32'hDEAD_BEEF});
      check("load_is_load", {135'd0, bus_if.mem_is_load}, 136'd1);

      // Held stall for three edges; SRAM output drops to zero after the first cycle
      bus_if.stall         = 6'b011000;
      bus_if.ex_to_mem_bus = mk_bus(0, 0, 0, 0, 32'hBFC0_0008, 0, 4'h0, 0, 1, 5'd9, 32'h5555_5555);
      for (int i = 0; i < 3; i++) begin
         cyc();
         bus_if.data_sram_rdata = 32'h0;
         at_neg();
         check("held_wb", bus_if.mem_to_wb_bus,
               {1'b0, 1'b0, 32'h0, 32'h0, 32'hBFC0_0004, 1'b1, 5'd8, 32'hDEAD_BEEF});
      end

      // Bubble, then the next NoStop edge loads the new bus
      bus_if.stall = 6'b001000;
      cyc();
      at_neg();
      check("bubble_wb", bus_if.mem_to_wb_bus, 136'd0);
      check("bubble_is_load", {135'd0, bus_if.mem_is_load}, 136'd0);

      // mthi-style pass-through
      bus_if.stall         = 6'b0;
      bus_if.ex_to_mem_bus = mk_bus(1, 0, 32'hCAFE_0001, 0, 32'hBFC0_000C, 0, 4'h0, 0, 0, 5'd0, 32'h0);
      cyc();
      at_neg();
      check("mthi_wb", bus_if.mem_to_wb_bus,
            {1'b1, 1'b0, 32'hCAFE_0001, 32'h0, 32'hBFC0_000C, 1'b0, 5'd0, 32'h0});

      // Store: not a load, write data is the ALU result
      bus_if.ex_to_mem_bus = mk_bus(0, 0, 0, 0, 32'hBFC0_0010, 1, 4'hF, 0, 0, 5'd0, 32'h0000_2000);
      cyc();
      at_neg();
      check("store_is_load", {135'd0, bus_if.mem_is_load}, 136'd0);
      check("store_wdata", {104'd0, bus_if.mem_to_wb_bus[31:0]}, {104'd0, 32'h0000_2000});

      // Back-to-back loads across one held cycle: the second uses live rdata
      bus_if.ex_to_mem_bus   = mk_bus(0, 0, 0, 0, 32'hBFC0_0014, 1, 4'h0, 1, 1, 5'd3, 32'h0000_3000);
      bus_if.data_sram_rdata = 32'h1111_1111;
      cyc();
      bus_if.stall = 6'b011000;
      cyc();
      bus_if.stall           = 6'b0;
      bus_if.ex_to_mem_bus   = mk_bus(0, 0, 0, 0, 32'hBFC0_0018, 1, 4'h0, 1, 1, 5'd4, 32'h0000_3004);
      bus_if.data_sram_rdata = 32'h2222_2222;
      cyc();
      at_neg();
      check("b2b_wdata", {104'd0, bus_if.mem_to_wb_bus[31:0]}, {104'd0, 32'h2222_2222});

      // Reset during a held load wins
      bus_if.stall = 6'b011000;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      at_neg();
      check("rst_held_wb", bus_if.mem_to_wb_bus, 136'd0);

      // Randomized traffic, checked every cycle by the model process
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       wen = 4'h0;
            1:       wen = 4'hF;
            default: wen = 4'($urandom);
         endcase
         r_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
         r_bus[42:39] = wen;
         bus_if.ex_to_mem_bus   = r_bus;
         bus_if.data_sram_rdata = $urandom;
         bus_if.stall           = 6'($urandom) & (($urandom_range(0, 2) == 0) ? 6'h3F : 6'h07);
         rst                    = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst = 1'b0;
      cyc();
      at_neg();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits between the execute stage and write-back. It registers the execute-to-memory bus and completes word loads using the synchronous data SRAM read data. It also holds that read data stable while the stage is stalled. It produces the memory-to-write-back bus and a same-cycle forwarding copy for the decode stage.

## Interface
- `EX_TO_MEM_WD`, 142: execute-to-memory bus width.
- `MEM_TO_WB_WD`, 136: memory-to-write-back bus width.
- `StallBus`, 6: stall vector width. Bit 3 = this stage, bit 4 = write-back. `Stop`=1, `NoStop`=0.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  `StallBus`  pipeline stall vector from the controller.
- `ex_to_mem_bus`  in  142  fields, MSB first:
  - hi_we[141], lo_we[140]
  - hi_result[139:108], lo_result[107:76]
  - pc[75:44]
  - data_ram_en[43], data_ram_wen[42:39]
  - sel_rf_res[38], rf_we[37], rf_waddr[36:32]
  - ex_result[31:0]
- `data_sram_rdata`  in  32  SRAM read data. Valid in the first cycle a load occupies this stage (the address was issued in the execute cycle).
- `mem_to_wb_bus`  out  136  fields, MSB first:
  - hi_we[135], lo_we[134]
  - hi_result[133:102], lo_result[101:70]
  - pc[69:38]
  - rf_we[37], rf_waddr[36:32], rf_wdata[31:0]
- `mem_to_id_forwarding`  out  136  bit-identical copy of `mem_to_wb_bus`.
- `mem_is_load`  out  1  the current stage instruction is a load (data_ram_en=1 and data_ram_wen=0).

## Operation
- Pipeline register `bus_r` (142 bits), updated on the clk rising edge:
  - rst: cleared to 0.
  - else if stall[3]=Stop and stall[4]=NoStop: cleared to 0 (bubble).
  - else if stall[3]=NoStop: loaded from `ex_to_mem_bus`.
  - else: held.
- Load detection: `is_load` = data_ram_en & (data_ram_wen==4'b0000). A store (wen=4'b1111) is not a load.
- Read-data hold register `rdata_h` (32 bits) and flag `first_r` (1 bit):
  - `first_r` is set to 1 on every edge that loads `bus_r` from the bus.
  - `first_r` is cleared to 0 on every other edge: held, bubble, or rst.
  - On an edge where `first_r`=1 and `bus_r` is held, `rdata_h` captures `data_sram_rdata`.
  - rst clears `rdata_h` to 0.
- Effective load data: `ld_data` = `first_r` ? `data_sram_rdata` : `rdata_h`.
- Write-data select: `rf_wdata` = sel_rf_res ? `ld_data` : ex_result.
- Pass-through: hi/lo fields, pc, rf_we and rf_waddr pass unchanged from `bus_r`. Write-back commits HI/LO.
- Bubble or empty stage: all outputs are 0, including rf_we=0, hi_we=0 and lo_we=0.
- The block never requests a stall itself.

## Timing
- Reset: `bus_r`, `rdata_h` and `first_r` are 0. Both output buses and `mem_is_load` are 0 in the cycle after the rst edge.
- Latency: one stage register. The instruction accepted at edge N appears on the outputs during cycle N→N+1.
- Outputs are combinational from `bus_r`, `first_r`, `rdata_h` and `data_sram_rdata`. No output depends on `ex_to_mem_bus` combinationally.
- Held stall (stall[3]=Stop, stall[4]=Stop), k cycles:
  - The output bus is constant for all k+1 cycles.
  - `rf_wdata` equals the rdata sampled in the first cycle, even if the SRAM output changes afterwards.
- Bubble edge: a load that leaves this stage with stall[3]=Stop and stall[4]=NoStop is replaced by zeros. Write-back must already have consumed it, so nothing is lost.
- Back-to-back loads: each new load sets `first_r` again and uses live rdata. A stale `rdata_h` is never selected in a first cycle.
- rst during a held load: takes priority. The next cycle shows all-zero outputs, and `rdata_h` is 0.

## Test plan
- Reset: assert rst for 2 cycles with a nonzero bus and rdata → both buses 0 and `mem_is_load`=0.
- ALU pass-through: bus with rf_we=1, waddr=5, ex_result=0x1234_5678, sel_rf_res=0 → one cycle later rf_wdata=0x1234_5678, waddr=5, pc is passed through.
- Load no stall: load with sel_rf_res=1 and rdata=0xDEAD_BEEF in the first cycle → rf_wdata=0xDEAD_BEEF, mem_is_load=1.
- Load held stall: same load, stall[3]=stall[4]=1 for 3 cycles, rdata changes to 0x0 after the first cycle → rf_wdata stays 0xDEAD_BEEF for all 4 cycles.
- Bubble: stall=6'b001000 at an edge → next cycle rf_we=0 and all outputs 0. The following NoStop edge loads the new bus.
- HI/LO and store: mthi-style bus (hi_we=1, hi_result=0xCAFE_0001) → passes unchanged. A store (en=1, wen=4'b1111) → mem_is_load=0 and rf_wdata=ex_result.
